// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the round-robin arbiter with registered output.
// Holds the lock FSM state encoding and the source-index width helper.
package rr_arb_pkg;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } arb_state_t;

    // Never returns zero, so an index port always has at least one bit.
    function automatic int idx_w(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/rr_prio_enc.sv
// Rotating priority encoder: first asserted request strictly after ptr,
// wrapping modulo NUM. Produces a one-hot grant and the matching index.
module rr_prio_enc #(
    parameter int NUM  = 4,
    parameter int CTRL = 2
) (
    input  logic [NUM-1:0]  req,
    input  logic [CTRL-1:0] ptr,
    output logic [NUM-1:0]  grant,
    output logic [CTRL-1:0] idx
);

    logic w_found;
    int   w_pos;

    always_comb begin
        grant   = '0;
        idx     = '0;
        w_found = 1'b0;
        w_pos   = 0;
        for (int k = 1; k <= NUM; k++) begin
            w_pos = (int'(ptr) + k) % NUM;
            if (!w_found && req[w_pos]) begin
                w_found      = 1'b1;
                grant[w_pos] = 1'b1;
                idx          = CTRL'(w_pos);
            end
        end
    end

endmodule

// File: rtl/rr_arb_dreg.sv
// Round-robin N:1 arbiter feeding a single output register, with optional
// grant locking until an end-of-transaction beat transfers.
module rr_arb_dreg
    import rr_arb_pkg::*;
#(
    parameter  int DIN  = 16,
    parameter  int NUM  = 4,
    parameter  int LOCK = 0,
    localparam int CTRL = idx_w(NUM)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM-1:0]     din_valid,
    input  logic [NUM*DIN-1:0] din_data,
    output logic [NUM-1:0]     din_ready,
    output logic               dout_valid,
    output logic [DIN-1:0]     dout_data,
    output logic [CTRL-1:0]    dout_ctrl,
    input  logic               dout_ready
);

    arb_state_t      r_state;
    arb_state_t      w_state_nxt;
    logic [CTRL-1:0] r_ptr;
    logic            r_dout_valid;
    logic [DIN-1:0]  r_dout_data;
    logic [CTRL-1:0] r_dout_ctrl;

    logic [NUM-1:0]  w_enc_grant;
    logic [CTRL-1:0] w_enc_idx;
    logic [NUM-1:0]  w_grant;
    logic [CTRL-1:0] w_sel_idx;
    logic [DIN-1:0]  w_sel_data;
    logic            w_reg_ready;
    logic            w_xfer;
    logic            w_eot;

    rr_prio_enc #(
        .NUM  (NUM),
        .CTRL (CTRL)
    ) u_enc (
        .req   (din_valid),
        .ptr   (r_ptr),
        .grant (w_enc_grant),
        .idx   (w_enc_idx)
    );

    // A held lock pins the grant to the owner even if it drops valid.
    always_comb begin
        w_grant   = w_enc_grant;
        w_sel_idx = w_enc_idx;
        if (r_state == LOCKED) begin
            w_grant        = '0;
            w_grant[r_ptr] = 1'b1;
            w_sel_idx      = r_ptr;
        end
    end

    assign w_reg_ready = !r_dout_valid || dout_ready;
    assign din_ready   = rst ? '0 : ({NUM{w_reg_ready}} & w_grant);
    assign w_xfer      = |(din_valid & din_ready);
    assign w_sel_data  = din_data[int'(w_sel_idx)*DIN +: DIN];
    assign w_eot       = w_sel_data[DIN-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= UNLOCKED;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (LOCK == 0) begin
            w_state_nxt = UNLOCKED;
        end else begin
            case (r_state)
                UNLOCKED: if (w_xfer && !w_eot) w_state_nxt = LOCKED;
                LOCKED:   if (w_xfer &&  w_eot) w_state_nxt = UNLOCKED;
                default:  w_state_nxt = UNLOCKED;
            endcase
        end
    end

    // Output register; ptr starts at NUM-1 so requester 0 wins first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr        <= CTRL'(NUM - 1);
            r_dout_valid <= 1'b0;
            r_dout_data  <= '0;
            r_dout_ctrl  <= '0;
        end else if (w_xfer) begin
            r_ptr        <= w_sel_idx;
            r_dout_valid <= 1'b1;
            r_dout_data  <= w_sel_data;
            r_dout_ctrl  <= w_sel_idx;
        end else if (w_reg_ready) begin
            r_dout_valid <= 1'b0;
        end
    end

    assign dout_valid = r_dout_valid;
    assign dout_data  = r_dout_data;
    assign dout_ctrl  = r_dout_ctrl;

endmodule

// File: tb/tb_rr_arb_dreg.sv
// Directed bench for rr_arb_dreg: one unlocked and one locking instance,
// each driven with hand-computed vectors.
module tb_rr_arb_dreg;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst0, rst1;
    logic [3:0]  dv0, dv1, rdy0, rdy1;
    logic [63:0] dd0, dd1;
    logic        ov0, ov1, dr0, dr1;
    logic [15:0] od0, od1;
    logic [1:0]  oc0, oc1;
    logic [15:0] d1 [4];

    assign dd1 = {d1[3], d1[2], d1[1], d1[0]};

    int n_vec = 0;
    int n_err = 0;

    rr_arb_dreg #(.DIN(16), .NUM(4), .LOCK(0)) u_dut0 (
        .clk(clk), .rst(rst0), .din_valid(dv0), .din_data(dd0), .din_ready(rdy0),
        .dout_valid(ov0), .dout_data(od0), .dout_ctrl(oc0), .dout_ready(dr0)
    );

    rr_arb_dreg #(.DIN(16), .NUM(4), .LOCK(1)) u_dut1 (
        .clk(clk), .rst(rst1), .din_valid(dv1), .din_data(dd1), .din_ready(rdy1),
        .dout_valid(ov1), .dout_data(od1), .dout_ctrl(oc1), .dout_ready(dr1)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst0 = 1'b1; rst1 = 1'b1;
        dv0  = 4'hF; dr0 = 1'b1;
        dd0  = 64'h0A03_0A02_0A01_0A00;
        dv1  = 4'h0; dr1 = 1'b1;
        for (int i = 0; i < 4; i++) d1[i] = 16'h0000;

        repeat (2) tick;
        chk("rst_valid", 32'(ov0), 32'h0);
        chk("rst_data",  32'(od0), 32'h0);
        chk("rst_ctrl",  32'(oc0), 32'h0);
        chk("rst_ready", 32'(rdy0), 32'h0);
        chk("rst_valid1", 32'(ov1), 32'h0);

        // full-rate round robin from reset
        @(negedge clk);
        rst0 = 1'b0;
        #1;
        chk("first_grant", 32'(rdy0), 32'h1);
        for (int i = 0; i < 5; i++) begin
            tick;
            chk("rr_valid", 32'(ov0), 32'h1);
            chk("rr_ctrl",  32'(oc0), 32'(i % 4));
            chk("rr_data",  32'(od0), 32'h0A00 | 32'(i % 4));
        end

        // backpressure: beat from requester 0 held
        dr0 = 1'b0;
        #1;
        chk("bp_ready", 32'(rdy0), 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("bp_data",  32'(od0), 32'h0A00);
            chk("bp_valid", 32'(ov0), 32'h1);
            chk("bp_ready", 32'(rdy0), 32'h0);
        end
        dr0 = 1'b1;
        #1;
        chk("drain_ready", 32'(rdy0), 32'h2);
        tick;
        chk("drain_ctrl", 32'(oc0), 32'h1);
        chk("drain_data", 32'(od0), 32'h0A01);
        dv0 = 4'h0;
        #1;
        chk("idle_ready", 32'(rdy0), 32'h0);
        tick;
        chk("idle_valid", 32'(ov0), 32'h0);

        // wrap-around from ptr=3 with requesters 0 and 2
        dv0 = 4'b1000;
        tick;
        chk("to3_ctrl", 32'(oc0), 32'h3);
        dv0 = 4'b0101;
        #1;
        chk("wrap_ready", 32'(rdy0), 32'h1);
        tick;
        chk("wrap_ctrl0", 32'(oc0), 32'h0);
        tick;
        chk("wrap_ctrl1", 32'(oc0), 32'h2);
        tick;
        chk("wrap_ctrl2", 32'(oc0), 32'h0);
        dv0 = 4'h0;

        // locking instance: requester 1 sends a 3-beat transaction
        @(negedge clk);
        rst1  = 1'b0;
        d1[1] = 16'h0011;
        d1[2] = 16'h8022;
        dv1   = 4'b0110;
        #1;
        chk("lk_first", 32'(rdy1), 32'h2);
        tick;
        chk("lk_ctrl0", 32'(oc1), 32'h1);
        chk("lk_data0", 32'(od1), 32'h0011);
        chk("lk_ready0", 32'(rdy1), 32'h2);
        d1[1] = 16'h0012;
        tick;
        chk("lk_ctrl1", 32'(oc1), 32'h1);
        chk("lk_data1", 32'(od1), 32'h0012);
        chk("lk_ready1", 32'(rdy1), 32'h2);
        dv1 = 4'b0100;
        #1;
        chk("lk_hold_ready", 32'(rdy1), 32'h2);
        tick;
        chk("lk_gap_valid", 32'(ov1), 32'h0);
        chk("lk_gap_ready", 32'(rdy1), 32'h2);
        dv1   = 4'b0110;
        d1[1] = 16'h8013;
        tick;
        chk("lk_ctrl2", 32'(oc1), 32'h1);
        chk("lk_data2", 32'(od1), 32'h8013);
        chk("unlk_ready", 32'(rdy1), 32'h4);
        tick;
        chk("next_ctrl", 32'(oc1), 32'h2);
        chk("next_data", 32'(od1), 32'h8022);
        chk("single_ready", 32'(rdy1), 32'h2);

        // lock onto requester 3, then reset while the beat is held
        dv1   = 4'b1000;
        d1[3] = 16'h0033;
        tick;
        chk("lk3_ctrl", 32'(oc1), 32'h3);
        chk("lk3_data", 32'(od1), 32'h0033);
        dr1 = 1'b0;
        dv1 = 4'b1010;
        #1;
        chk("lk3_bp_ready", 32'(rdy1), 32'h0);
        #1;
        rst1 = 1'b1;
        #1;
        chk("arst_valid", 32'(ov1), 32'h0);
        chk("arst_data",  32'(od1), 32'h0);
        chk("arst_ctrl",  32'(oc1), 32'h0);
        chk("arst_ready", 32'(rdy1), 32'h0);
        @(negedge clk);
        rst1 = 1'b0;
        dr1  = 1'b1;
        #1;
        chk("post_rst_ready", 32'(rdy1), 32'h2);
        tick;
        chk("post_rst_ctrl", 32'(oc1), 32'h1);
        chk("post_rst_data", 32'(od1), 32'h8013);
        dv1 = 4'h0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
